// File: rtl/rca_seq_ctrl.sv
// Sequential WIDTH-bit add/subtract built from one SLICE-bit ripple-carry slice.
// Each operation takes NSLICE cycles, LSB slice first, and is framed by valid/ready handshakes.
module rca_seq_ctrl #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned SLICE = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ovf;

    logic [SLICE-1:0]   w_a_sl;
    logic [SLICE-1:0]   w_b_sl;
    logic [SLICE:0]     w_ext;
    logic [SLICE-1:0]   w_sum;
    logic               w_c;
    logic               w_last;
    logic               w_ovf;

    // Shared ripple-carry slice operating on the slice selected by the counter
    always_comb begin
        w_a_sl = r_a[r_cnt*SLICE +: SLICE];
        w_b_sl = r_b[r_cnt*SLICE +: SLICE];
        w_ext  = (SLICE+1)'(w_a_sl) + (SLICE+1)'(w_b_sl) + (SLICE+1)'(r_carry);
        w_sum  = w_ext[SLICE-1:0];
        w_c    = w_ext[SLICE];
        w_last = (r_cnt == CW'(NSLICE - 1));
        w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[SLICE-1] != r_a[WIDTH-1]);
    end

    // Sequencer: accept, iterate slices, hold the result until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_s[r_cnt*SLICE +: SLICE] <= w_sum;
                    r_carry                   <= w_c;
                    if (w_last) begin
                        r_cout  <= w_c;
                        r_ovf   <= w_ovf;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode the registered state only
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl: hand-computed vectors, latency, backpressure and
// mid-operation reset scenarios.
module tb_rca_seq_ctrl;

    localparam int unsigned WIDTH = 36;
    localparam int unsigned SLICE = 9;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    rca_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from IDLE; returns cycles from accept edge to out_valid
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin, input logic tsub, output int lat);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        lat      = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Release the result and return to IDLE
    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (s !== 36'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs s=%h cout=%b ovf=%b required 0/0/0", s, cout, ovf);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry_chain();
        int lat;
        run_op(36'hFFFFFFFFF, 36'h0, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL carry_latency got=%0d required=4", lat);
        end
        checks++;
        if (s !== 36'h000000000 || cout !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL carry_chain s=%h cout=%b ovf=%b required 000000000/1/0", s, cout, ovf);
        end
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL carry_return_idle in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        int lat;
        run_op(36'h000000003, 36'h000000001, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 4 || s !== 36'h000000005 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_small lat=%0d s=%h cout=%b ovf=%b required 4/000000005/0/0", lat, s, cout, ovf);
        end
        finish_op();
        run_op(36'h000000000, 36'hFFFFFFFFD, 1'b1, 1'b0, lat);
        checks++;
        if (s !== 36'hFFFFFFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_neg s=%h cout=%b ovf=%b required FFFFFFFFE/0/0", s, cout, ovf);
        end
        finish_op();
    endtask

    task automatic test_sub();
        int lat;
        run_op(36'd5, 36'd7, 1'b1, 1'b1, lat);
        checks++;
        if (s !== 36'hFFFFFFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_5_7 s=%h cout=%b ovf=%b required FFFFFFFFE/0/0", s, cout, ovf);
        end
        finish_op();
        run_op(36'd7, 36'd5, 1'b0, 1'b1, lat);
        checks++;
        if (s !== 36'h000000002 || cout !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_7_5 s=%h cout=%b ovf=%b required 000000002/1/0", s, cout, ovf);
        end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(36'h7FFFFFFFF, 36'h000000001, 1'b0, 1'b0, lat);
        checks++;
        if (s !== 36'h800000000 || cout !== 1'b0 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_add s=%h cout=%b ovf=%b required 800000000/0/1", s, cout, ovf);
        end
        finish_op();
        run_op(36'h800000000, 36'h000000001, 1'b0, 1'b1, lat);
        checks++;
        if (s !== 36'h7FFFFFFFF || cout !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sub s=%h cout=%b ovf=%b required 7FFFFFFFF/1/1", s, cout, ovf);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        run_op(36'h123456789, 36'h111111111, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 4 || s !== 36'h23456789A || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_result lat=%0d s=%h cout=%b ovf=%b required 4/23456789A/0/0", lat, s, cout, ovf);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 3 == 1);
            a        = 36'hABCDEF012;
            b        = 36'h000000FFF;
            cin      = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (s !== 36'h23456789A || cout !== 1'b0 || ovf !== 1'b0 ||
                in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d s=%h cout=%b ovf=%b in_ready=%b out_valid=%b required 23456789A/0/0/0/1",
                         i, s, cout, ovf, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_accept in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int  lat;
        logic seen;
        a        = 36'h0000000AA;
        b        = 36'h000000055;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_busy in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_async in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_output saw_activity=%b required 0", seen);
        end
        run_op(36'd1, 36'd2, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 4 || s !== 36'h000000004 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL rst_recover lat=%0d s=%h cout=%b ovf=%b required 4/000000004/0/0", lat, s, cout, ovf);
        end
        finish_op();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_carry_chain();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Multi-cycle sequencer that computes a WIDTH-bit add or subtract by reusing one SLICE-bit ripple-carry slice over WIDTH/SLICE cycles, LSB slice first. It carries between slices through an internal register. It is the area-reduced alternative to the full-width 36-bit ripple-carry adder. Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 36, operand/result width; must be an integer multiple of SLICE
SLICE, 9, bits added per cycle by the internal ripple-carry slice
NSLICE, WIDTH/SLICE (derived, localparam), slice cycles per operation

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand request
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in; ignored when sub=1
sub  in  1  1 = compute A - B
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
s  out  WIDTH  sum/difference, registered
cout  out  1  carry out of MSB; for sub, 1 = no borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (async, active-high): state=IDLE, slice counter=0, carry reg=0, s=0, cout=0, ovf=0, out_valid=0. in_ready=1 because state is IDLE. Inputs are ignored while rst=1.
- Reset mid-operation: abandons the operation immediately, with no partial result or out_valid pulse.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- IDLE:
  - Accept on a clk edge with in_valid && in_ready.
  - Capture a_reg=a and b_reg = sub ? ~b : b.
  - Set carry = sub ? 1 : cin. Clear counter. Go to RUN.
- RUN, slice k=counter:
  - {c, sum} = a_reg[k*SLICE +: SLICE] + b_reg[k*SLICE +: SLICE] + carry.
  - Write sum into s[k*SLICE +: SLICE]. carry <= c. counter++.
  - When k==NSLICE-1: cout <= c; ovf <= (a_reg[MSB]==b_reg[MSB]) && (sum[SLICE-1] != a_reg[MSB]); counter <= 0; go to DONE.
- DONE: s, cout, ovf held stable. On a clk edge with out_ready=1, go to IDLE. If out_ready=0, hold indefinitely (backpressure).
- Latency: accept edge E. out_valid goes high after edge E+NSLICE (4 cycles at defaults).
- Minimum issue interval: NSLICE+2 cycles with out_ready tied high (IDLE→RUN×NSLICE→DONE→IDLE).
- No new operand is accepted in RUN or DONE. in_valid is don't-care there, and a/b/cin/sub changes after acceptance have no effect.
- s is only defined while out_valid=1. During RUN it holds a mix of stale and new slices.
- Arithmetic is modulo 2^WIDTH, with the carry out reported in cout. No saturation.

Test Plan:
1. Reset, then a=36'hFFFFFFFFF, b=0, cin=1, sub=0 → out_valid exactly 4 cycles after accept; s=36'h000000000, cout=1, ovf=0. Checks carry crossing all slice boundaries.
2. a=36'h000000003, b=36'h000000001, cin=1 → s=36'h000000005, cout=0, ovf=0. Then a=0, b=36'hFFFFFFFFD, cin=1 → s=36'hFFFFFFFFE, cout=0.
3. sub=1, a=5, b=7, cin=1 (ignored) → s=36'hFFFFFFFFE, cout=0, ovf=0. Then sub=1, a=7, b=5 → s=2, cout=1.
4. a=36'h7FFFFFFFF, b=1, cin=0 → s=36'h800000000, ovf=1, cout=0. Then sub=1, a=36'h800000000, b=1 → s=36'h7FFFFFFFF, ovf=1.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid → s/cout/ovf stable and in_ready=0 throughout; in_valid pulsed during that time is not accepted. Release out_ready → in_ready=1 on the next cycle.
6. Assert rst during RUN at slice 2 → out_valid never rises, in_ready=1 immediately. After release, a=1, b=2, cin=1 → s=4, and the full 4-cycle latency is re-measured.
